fetch_seq: RTL and testbench
============================

# fetch_seq

Byte-serial instruction fetch sequencer for the Y86 front end. It drives the address of the byte-wide instruction memory one byte per cycle and decodes the instruction length from the first byte. It assembles the 1–6 byte instruction into the 48-bit instruction bus and presents it to decode with a valid/ready handshake. It also handles PC advance, redirects from execute, and stopping on `halt`.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous reset, active-high.
- `redirect`  in  1: abort the current fetch and restart at `redirect_pc`.
- `redirect_pc`  in  ADDR_W: new fetch address.
- `mem_addr`  out  ADDR_W: byte address to the instruction memory.
- `mem_data`  in  8: byte at `mem_addr`, combinational, same cycle.
- `inst`  out  48: assembled instruction, byte0 in [47:40], byte1 in [39:32], …, byte5 in [7:0]; unfetched bytes are 0.
- `inst_len`  out  3: instruction length in bytes (1–6).
- `inst_pc`  out  ADDR_W: address of byte0.
- `inst_bad`  out  1: byte0 icode not a legal Y86 opcode.
- `inst_valid`  out  1: `inst`/`inst_len`/`inst_pc`/`inst_bad` are valid.
- `inst_ready`  in  1: decode accepts this cycle.
- `halted`  out  1: `halt` instruction accepted; fetch stopped.

## Operation
- States: FETCH, HOLD, HALTED.
- Registers: `pc`, `cnt` (byte index 0–5), `len`, instruction byte buffer.
- Length decode from icode = byte0[7:4]:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte.
  - 2 (rrmovl/cmov), 6 (OPl), A (pushl), B (popl): 2 bytes.
  - 7 (jXX), 8 (call): 5 bytes.
  - 3 (irmovl), 4 (rmmovl), 5 (mrmovl): 6 bytes.
  - C–F: length 1 with `inst_bad`=1.
- FETCH:
  - `mem_addr` = `pc` + `cnt`; capture `mem_data` into byte slot `cnt`.
  - At `cnt`=0, latch `len` from the decode above.
  - If `cnt`+1 == length, go to HOLD; otherwise `cnt`++.
  - A 1-byte instruction goes FETCH→HOLD in one cycle.
- HOLD:
  - `inst_valid`=1; all outputs stable until the handshake.
  - On `inst_valid`&`inst_ready`: `pc` += `len` (modulo 2^ADDR_W), clear `cnt` and the byte buffer.
  - Next state is HALTED if icode==0 and not bad, else FETCH.
- HALTED: `halted`=1, `inst_valid`=0, `mem_addr`=`pc`. Leaves only on `redirect`.
- Redirect, from any state and taking priority over the handshake:
  - Next cycle: `pc`=`redirect_pc`, `cnt`=0, buffer cleared, state FETCH.
  - The instruction in HOLD is dropped even if `inst_ready`=1 in the same cycle; no valid is issued for it.
- Reset (asynchronous):
  - State FETCH, `pc`=0, `cnt`=0, `len`=1, buffer=0.
  - Outputs: `inst_valid`=0, `inst`=0, `inst_len`=1, `inst_pc`=0, `inst_bad`=0, `halted`=0, `mem_addr`=0.
  - Reset mid-fetch discards partial bytes.

## Timing
- Fetch latency: an N-byte instruction occupies N FETCH cycles. `inst_valid` rises at the edge ending the Nth byte cycle.
- Throughput with `inst_ready` held 1: one instruction per N+1 cycles (HOLD costs one cycle).
- `inst_ready` is sampled only in HOLD and ignored elsewhere. Backpressure holds HOLD indefinitely with outputs frozen.
- `mem_addr` is combinational from registered `pc`/`cnt`; no dependence on `mem_data`.
- Address wrap: `pc`+`cnt` and `pc`+`len` wrap modulo 2^ADDR_W; no fault.
- `redirect` first affects `mem_addr` in the cycle after it is sampled.

## Test plan
- Reset, then memory 10 30 F0 44 33 22 11 00, `inst_ready`=1:
  - nop: valid after 1 cycle, `inst`=0x100000000000, len 1, pc 0.
  - irmovl: valid 6 cycles later, `inst`=0x30F044332211, len 6, `inst_pc`=1.
  - halt: valid at pc 7, then `halted`=1, `mem_addr` frozen at 8.
- Backpressure: `inst_ready`=0 for 5 cycles on a 2-byte `60 12` → `inst_valid` held, `inst`=0x601200000000 stable, `pc` unchanged; ready=1 → pc += 2.
- Redirect during byte 3 of a 5-byte `call`, `redirect_pc`=0x40 → partial discarded, next `mem_addr`=0x40, no spurious valid.
- Redirect and `inst_ready` together in HOLD → instruction dropped, fetch restarts at `redirect_pc`, no pc += len.
- Byte0 = 0xE5 → len 1, `inst_bad`=1, `inst`=0xE50000000000, fetch continues at pc+1.
- Wrap: `redirect_pc`=0xFFFFFFFE, memory `20 12` → bytes read from 0xFFFFFFFE and 0xFFFFFFFF, next pc 0x00000000. Assert `rst` mid-fetch → all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_seq.sv
// Byte-serial Y86 instruction fetch: one memory byte per cycle, length decode from byte0,
// 48-bit assembled instruction handed to decode over a valid/ready handshake.
module fetch_seq #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [47:0]       inst,
    output logic [2:0]        inst_len,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_bad,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              halted
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic              bad_q, bad_d;
    logic [47:0]       buf_q, buf_d;

    logic [2:0] dec_len;
    logic       dec_bad;
    logic [2:0] cur_len;

    // Length decode is only meaningful when mem_data holds byte0 (cnt == 0).
    always_comb begin
        dec_len = 3'd1;
        dec_bad = 1'b0;
        case (mem_data[7:4])
            4'h0, 4'h1, 4'h9:       dec_len = 3'd1;
            4'h2, 4'h6, 4'hA, 4'hB: dec_len = 3'd2;
            4'h7, 4'h8:             dec_len = 3'd5;
            4'h3, 4'h4, 4'h5:       dec_len = 3'd6;
            default: begin
                dec_len = 3'd1;
                dec_bad = 1'b1;
            end
        endcase
    end

    assign cur_len = (cnt_q == 3'd0) ? dec_len : len_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        bad_d   = bad_q;
        buf_d   = buf_q;
        case (state_q)
            FETCH: begin
                for (int i = 0; i < 6; i++) begin
                    if (cnt_q == 3'(i)) buf_d[8*(5-i) +: 8] = mem_data;
                end
                if (cnt_q == 3'd0) begin
                    len_d = dec_len;
                    bad_d = dec_bad;
                end
                if (cnt_q + 3'd1 == cur_len) state_d = HOLD;
                else                         cnt_d   = cnt_q + 3'd1;
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_d    = pc_q + ADDR_W'(len_q);
                    cnt_d   = 3'd0;
                    buf_d   = '0;
                    state_d = (buf_q[47:44] == 4'h0 && !bad_q) ? HALTED : FETCH;
                end
            end
            HALTED: ;
            default: state_d = FETCH;
        endcase
        // Redirect wins over the handshake: a held instruction is dropped.
        if (redirect) begin
            pc_d    = redirect_pc;
            cnt_d   = 3'd0;
            buf_d   = '0;
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            cnt_q   <= 3'd0;
            len_q   <= 3'd1;
            bad_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bad_q   <= bad_d;
            buf_q   <= buf_d;
        end
    end

    assign mem_addr   = pc_q + ADDR_W'(cnt_q);
    assign inst       = buf_q;
    assign inst_len   = len_q;
    assign inst_pc    = pc_q;
    assign inst_bad   = bad_q;
    assign inst_valid = (state_q == HOLD);
    assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed vector bench for fetch_seq: a per-cycle table of inputs and expected outputs,
// followed by hand-written redirect / asynchronous-reset sequences.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic [47:0] inst;
    logic [2:0]  inst_len;
    logic [31:0] inst_pc;
    logic        inst_bad;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic        halted;

    logic [7:0] mem [256];
    assign mem_data = mem[mem_addr[7:0]];

    always #5 clk = ~clk;

    fetch_seq #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .inst        (inst),
        .inst_len    (inst_len),
        .inst_pc     (inst_pc),
        .inst_bad    (inst_bad),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .halted      (halted)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        valid;
        logic [47:0] inst;
        logic [2:0]  len;
        logic [31:0] pc;
        logic        bad;
        logic        halted;
        logic [31:0] addr;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic [31:0] rpc, input logic rdy,
                       input logic v, input logic [47:0] ins, input logic [2:0] len,
                       input logic [31:0] pc, input logic bad, input logic h,
                       input logic [31:0] addr);
        vec_t x;
        x.redir = r; x.rpc = rpc; x.rdy = rdy; x.valid = v; x.inst = ins; x.len = len;
        x.pc = pc; x.bad = bad; x.halted = h; x.addr = addr;
        vq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid"},  48'(inst_valid), 48'd0);
        chk({tag, " inst"},   inst,            48'd0);
        chk({tag, " len"},    48'(inst_len),   48'd1);
        chk({tag, " pc"},     48'(inst_pc),    48'd0);
        chk({tag, " bad"},    48'(inst_bad),   48'd0);
        chk({tag, " halted"}, 48'(halted),     48'd0);
        chk({tag, " addr"},   48'(mem_addr),   48'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        {mem[0], mem[1], mem[2], mem[3]} = {8'h10, 8'h30, 8'hF0, 8'h44};
        {mem[4], mem[5], mem[6], mem[7]} = {8'h33, 8'h22, 8'h11, 8'h00};
        {mem[8'h10], mem[8'h11]} = {8'h60, 8'h12};
        {mem[8'h12], mem[8'h13], mem[8'h14], mem[8'h15], mem[8'h16]} =
            {8'h80, 8'h00, 8'h01, 8'h00, 8'h00};
        {mem[8'h40], mem[8'h41], mem[8'h42]} = {8'hE5, 8'h20, 8'h12};
        {mem[8'hFE], mem[8'hFF]} = {8'h20, 8'h12};

        // nop, irmovl, halt from address 0
        add(0, 0, 1, 0, 48'h0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 48'h100000000000, 1, 0, 0, 0, 0);
        for (int a = 1; a <= 6; a++) add(0, 0, 1, 0, 48'h0, 0, 1, 0, 0, 32'(a));
        add(0, 0, 1, 1, 48'h30F044332211, 6, 1, 0, 0, 6);
        add(0, 0, 1, 0, 48'h0, 0, 7, 0, 0, 7);
        add(0, 0, 1, 1, 48'h000000000000, 1, 7, 0, 0, 7);
        add(0, 0, 1, 0, 48'h0, 0, 8, 0, 1, 8);
        // leave HALTED by redirect to 0x10 (60 12), then backpressure 5 cycles
        add(1, 32'h10, 1, 0, 48'h0, 0, 8, 0, 1, 8);
        add(0, 0, 1, 0, 48'h0, 0, 32'h10, 0, 0, 32'h10);
        add(0, 0, 0, 0, 48'h0, 0, 32'h10, 0, 0, 32'h11);
        for (int k = 0; k < 5; k++) add(0, 0, 0, 1, 48'h601200000000, 2, 32'h10, 0, 0, 32'h11);
        add(0, 0, 1, 1, 48'h601200000000, 2, 32'h10, 0, 0, 32'h11);
        // call at 0x12, redirect to 0x40 on its third byte
        add(0, 0, 1, 0, 48'h0, 0, 32'h12, 0, 0, 32'h12);
        add(0, 0, 1, 0, 48'h0, 0, 32'h12, 0, 0, 32'h13);
        add(1, 32'h40, 1, 0, 48'h0, 0, 32'h12, 0, 0, 32'h14);
        // bad opcode E5, then rrmovl dropped by redirect+ready in HOLD
        add(0, 0, 1, 0, 48'h0, 0, 32'h40, 0, 0, 32'h40);
        add(0, 0, 1, 1, 48'hE50000000000, 1, 32'h40, 1, 0, 32'h40);
        add(0, 0, 1, 0, 48'h0, 0, 32'h41, 0, 0, 32'h41);
        add(0, 0, 1, 0, 48'h0, 0, 32'h41, 0, 0, 32'h42);
        add(1, 32'hFFFF_FFFE, 1, 1, 48'h201200000000, 2, 32'h41, 0, 0, 32'h42);
        // address wrap
        add(0, 0, 1, 0, 48'h0, 0, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFE);
        add(0, 0, 1, 0, 48'h0, 0, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFF);
        add(0, 0, 1, 1, 48'h201200000000, 2, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFF);
        add(0, 0, 1, 0, 48'h0, 0, 32'h0, 0, 0, 32'h0);

        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("in_reset");
        rst = 1'b0;

        foreach (vq[i]) begin
            redirect    = vq[i].redir;
            redirect_pc = vq[i].rpc;
            inst_ready  = vq[i].rdy;
            #1;
            chk($sformatf("v%0d valid", i),  48'(inst_valid), 48'(vq[i].valid));
            chk($sformatf("v%0d halted", i), 48'(halted),     48'(vq[i].halted));
            chk($sformatf("v%0d addr", i),   48'(mem_addr),   48'(vq[i].addr));
            chk($sformatf("v%0d pc", i),     48'(inst_pc),    48'(vq[i].pc));
            if (vq[i].valid) begin
                chk($sformatf("v%0d inst", i), inst,           vq[i].inst);
                chk($sformatf("v%0d len", i),  48'(inst_len),  48'(vq[i].len));
                chk($sformatf("v%0d bad", i),  48'(inst_bad),  48'(vq[i].bad));
            end
            @(negedge clk);
        end

        // Reset asserted between edges in the middle of fetching the call at 0x12.
        redirect = 1'b1;
        redirect_pc = 32'h12;
        @(negedge clk);
        redirect = 1'b0;
        #1 chk("mid addr0", 48'(mem_addr), 48'h12);
        @(negedge clk);
        @(negedge clk);
        #1 chk("mid addr2", 48'(mem_addr), 48'h14);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk_reset_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst valid", 48'(inst_valid), 48'd1);
        chk("post_rst inst",  inst,            48'h100000000000);
        chk("post_rst pc",    48'(inst_pc),    48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
